// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Target end of the nano_rv32i data port. This is a word-organised RAM
//   with byte-lane writes and registered reads. The read latency is
//   programmable, and every transaction ends with a completion pulse.
//
// Parameters
//   ADDR_WIDTH : word-address bits; capacity is 2**ADDR_WIDTH words.
//   READ_LAT   : cycles from read acceptance to d_ready_o (1..15).
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   d_addr_i   : byte address from the core
//   d_data_i   : write data from the core
//   d_rd_i     : read request
//   d_wr_i     : write request (informational; lanes come from d_we_i)
//   d_we_i     : byte-lane write enables
//   d_data_o   : read data, held until the next read response
//   d_ready_o  : one-cycle completion pulse
//   d_err_o    : one-cycle out-of-range pulse, coincident with d_ready_o
//   d_busy_o   : high while a read is waiting; requests are then ignored
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [3:0]  d_we_i,
  output logic [31:0] d_data_o,
  output logic        d_ready_o,
  output logic        d_err_o,
  output logic        d_busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cap_q, cap_d;
  logic        cap_err_q, cap_err_d;
  logic [31:0] hold_q, hold_d;
  logic        wr_ack_q, wr_ack_d;
  logic        wr_err_q, wr_err_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  can_accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  mem_wr;
  logic                  resp;

  // The write strobe and the low address bits carry no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, d_wr_i, d_addr_i[1:0]};

  assign word_idx   = d_addr_i[ADDR_WIDTH+1:2];
  assign in_range   = (d_addr_i[31:ADDR_WIDTH+2] == '0);
  // The RESP cycle is also an accepting cycle. This lets a new request
  // follow a response without a bubble.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_RESP);
  assign rd_acc     = can_accept & d_rd_i;
  assign wr_acc     = can_accept & (|d_we_i);
  assign mem_wr     = wr_acc & in_range;
  assign resp       = (state_q == S_RESP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    cap_err_d = cap_err_q;
    hold_d    = hold_q;
    // A write that collides with a read is acknowledged by the read
    // response alone, so only one ready pulse is produced.
    wr_ack_d  = wr_acc & ~rd_acc;
    wr_err_d  = wr_acc & ~rd_acc & ~in_range;

    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        hold_d  = cap_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The capture uses the pre-edge RAM contents. This makes a same-cycle
    // read and write to one word return the old data.
    if (rd_acc) begin
      cap_d     = in_range ? mem_q[word_idx] : 32'h0;
      cap_err_d = ~in_range;
      if (READ_LAT == 1) begin
        state_d = S_RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = S_WAIT;
        cnt_d   = LAT_INIT;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      cap_q     <= 32'h0;
      cap_err_q <= 1'b0;
      hold_q    <= 32'h0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      cap_err_q <= cap_err_d;
      hold_q    <= hold_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // RAM contents survive reset, so this storage is deliberately unreset.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (d_we_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= d_data_i[8*b +: 8];
        end
      end
    end
  end

  assign d_data_o  = resp ? cap_q : hold_q;
  assign d_ready_o = resp | wr_ack_q;
  assign d_err_o   = (resp & cap_err_q) | wr_err_q;
  assign d_busy_o  = (state_q == S_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. It uses two instances: dutA
//   with READ_LAT=1 and dutB with READ_LAT=4. The two instances share
//   address and data. The request strobes are steered to one instance
//   by 'sel'.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  we = '0;

  logic [31:0] dataA, dataB;
  logic        readyA, readyB, errA, errB, busyA, busyB;

  logic [31:0] dataS;
  logic        readyS, errS, busyS;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .READ_LAT(1)) dutA (
    .clk_i    (clk),
    .rst_i    (rst),
    .d_addr_i (addr),
    .d_data_i (wdata),
    .d_rd_i   (rd & ~sel),
    .d_wr_i   (wr & ~sel),
    .d_we_i   (sel ? 4'h0 : we),
    .d_data_o (dataA),
    .d_ready_o(readyA),
    .d_err_o  (errA),
    .d_busy_o (busyA)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .READ_LAT(4)) dutB (
    .clk_i    (clk),
    .rst_i    (rst),
    .d_addr_i (addr),
    .d_data_i (wdata),
    .d_rd_i   (rd & sel),
    .d_wr_i   (wr & sel),
    .d_we_i   (sel ? we : 4'h0),
    .d_data_o (dataB),
    .d_ready_o(readyB),
    .d_err_o  (errB),
    .d_busy_o (busyB)
  );

  assign dataS  = sel ? dataB  : dataA;
  assign readyS = sel ? readyB : readyA;
  assign errS   = sel ? errB   : errA;
  assign busyS  = sel ? busyB  : busyA;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task applyStimulus(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    rd    = r;
    wr    = (w != 4'h0);
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  // Issues a write. It then checks the ready and err pulse one cycle after
  // the accepting edge.
  task doWrite(input string tag, input logic [31:0] a, input logic [31:0] d,
               input logic [3:0] w, input logic expErr);
    applyStimulus(1'b0, w, a, d);
    @(posedge clk);
    #1 applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({tag, " ready"}, 32'(readyS), 32'h1);
    checkOutput({tag, " err"}, 32'(errS), 32'(expErr));
  endtask

  // Issues a read, optionally with a same-cycle write. Busy and ready are
  // checked every cycle up to the latency. The task then checks that no
  // second ready pulse follows.
  task doRead(input string tag, input logic [31:0] a, input logic [3:0] w,
              input logic [31:0] d, input int lat,
              input logic [31:0] expData, input logic expErr);
    applyStimulus(1'b1, w, a, d);
    @(posedge clk);
    #1 applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      checkOutput({tag, " ready"}, 32'(readyS), 32'(c == lat));
      checkOutput({tag, " busy"}, 32'(busyS), 32'(c < lat));
      if (c == lat) begin
        checkOutput({tag, " data"}, dataS, expData);
        checkOutput({tag, " err"}, 32'(errS), 32'(expErr));
      end
    end
    @(negedge clk);
    checkOutput({tag, " no 2nd ready"}, 32'(readyS), 32'h0);
  endtask

  initial begin
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rstA data", dataA, 32'h0);
    checkOutput("rstA ready", 32'(readyA), 32'h0);
    checkOutput("rstA err", 32'(errA), 32'h0);
    checkOutput("rstA busy", 32'(busyA), 32'h0);
    checkOutput("rstB data", dataB, 32'h0);
    checkOutput("rstB ready", 32'(readyB), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // READ_LAT=1 instance
    sel = 1'b0;
    doWrite("wr10", 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    doRead("rd10", 32'h10, 4'h0, 32'h0, 1, 32'hDEADBEEF, 1'b0);

    // These writes are back to back. Each one produces its own ready pulse.
    doWrite("wr20 full", 32'h20, 32'h11223344, 4'hF, 1'b0);
    doWrite("wr20 lane0", 32'h20, 32'h000000AA, 4'b0001, 1'b0);
    doWrite("wr20 lane3", 32'h20, 32'hBB000000, 4'b1000, 1'b0);
    checkOutput("hold after wr", dataA, 32'hDEADBEEF);
    doRead("rd20", 32'h20, 4'h0, 32'h0, 1, 32'hBB2233AA, 1'b0);

    doWrite("wr30", 32'h30, 32'h00000005, 4'hF, 1'b0);
    doRead("coll30", 32'h30, 4'hF, 32'h00000009, 1, 32'h00000005, 1'b0);
    doRead("rd30", 32'h30, 4'h0, 32'h0, 1, 32'h00000009, 1'b0);

    doWrite("wr0", 32'h0, 32'h12345678, 4'hF, 1'b0);
    doRead("oorA rd", 32'h00001000, 4'h0, 32'h0, 1, 32'h0, 1'b1);
    doWrite("oorA wr", 32'h00001000, 32'hFFFFFFFF, 4'hF, 1'b1);
    doRead("rd0", 32'h0, 4'h0, 32'h0, 1, 32'h12345678, 1'b0);

    // READ_LAT=4 instance. A write presented during the wait is ignored.
    sel = 1'b1;
    doWrite("wr40", 32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
    applyStimulus(1'b1, 4'h0, 32'h40, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("lat4 t1 busy", 32'(busyS), 32'h1);
    checkOutput("lat4 t1 ready", 32'(readyS), 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 4'hF, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("lat4 t2 busy", 32'(busyS), 32'h1);
    checkOutput("lat4 t2 ready", 32'(readyS), 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("lat4 t3 busy", 32'(busyS), 32'h1);
    checkOutput("lat4 t3 ready", 32'(readyS), 32'h0);
    @(negedge clk);
    checkOutput("lat4 t4 ready", 32'(readyS), 32'h1);
    checkOutput("lat4 t4 busy", 32'(busyS), 32'h0);
    checkOutput("lat4 t4 data", dataS, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("lat4 t5 ready", 32'(readyS), 32'h0);
    doRead("rd40", 32'h40, 4'h0, 32'h0, 4, 32'hCAFEF00D, 1'b0);
    doRead("oorB rd", 32'h00001000, 4'h0, 32'h0, 4, 32'h0, 1'b1);
    doRead("rd40 again", 32'h40, 4'h0, 32'h0, 4, 32'hCAFEF00D, 1'b0);

    // A reset asserted while the read is waiting discards the response.
    applyStimulus(1'b1, 4'h0, 32'h40, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst busy", 32'(busyS), 32'h0);
    checkOutput("midrst ready", 32'(readyS), 32'h0);
    checkOutput("midrst data", dataS, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("postrst ready", 32'(readyS), 32'h0);
    end
    checkOutput("postrst data", dataS, 32'h0);
    doRead("rd40 kept", 32'h40, 4'h0, 32'h0, 4, 32'hCAFEF00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
